// File: rtl/opc5ls_intc_pkg.sv
// Shared definitions for the OPC5LS interrupt controller: register offsets,
// FSM state encodings and the "nothing to claim" read value.
package opc5ls_intc_pkg;

  localparam logic [2:0] OFS_PENDING = 3'd0;
  localparam logic [2:0] OFS_MASK    = 3'd1;
  localparam logic [2:0] OFS_EDGE    = 3'd2;
  localparam logic [2:0] OFS_CLAIM   = 3'd3;
  localparam logic [2:0] OFS_EOI     = 3'd4;
  localparam logic [2:0] OFS_STATUS  = 3'd5;

  localparam logic [15:0] CLAIM_NONE = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ASSERT    = 2'd1,
    ST_INSERVICE = 2'd2
  } state_t;

endpackage

// File: rtl/opc5ls_intc_if.sv
// CPU register bus of the interrupt controller.
// Bus semantics: a register access happens on a rising clk edge while cs=1;
// rnw selects read (1) or write (0). There is no ready: every access completes
// in the cycle it is presented. rdata is combinational from cs and address.
interface opc5ls_intc_if;
  logic        cs;
  logic [2:0]  address;
  logic        rnw;
  logic [15:0] wdata;
  logic [15:0] rdata;

  modport master (output cs, output address, output rnw, output wdata, input rdata);
  modport slave  (input cs, input address, input rnw, input wdata, output rdata);
endinterface

// File: rtl/opc5ls_intc_prio.sv
// Lowest-index-first priority encoder: bit 0 wins.
module opc5ls_intc_prio #(
  parameter int NSRC = 8
) (
  input  logic [NSRC-1:0] req,
  output logic            valid,
  output logic [3:0]      id
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    valid = |req;
    id    = 4'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) id = 4'(i);
    end
  end

endmodule

// File: rtl/opc5ls_intc.sv
// OPC5LS interrupt controller: pending/mask/edge registers, claim/EOI FSM and
// a registered active-low interrupt to the CPU.
// Optional build macro INTC_SYNC_EN: adds a 2-flop synchronizer on irq.
module opc5ls_intc
  import opc5ls_intc_pkg::*;
#(
  parameter int NSRC = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq,
  opc5ls_intc_if.slave    bus,
  output logic            int_b,
  output state_t          dbg_state
);

  logic [NSRC-1:0] irq_s;
  logic [NSRC-1:0] irq_prev;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] edge_mode;
  logic [NSRC-1:0] pending_nxt;
  logic [NSRC-1:0] edge_det;
  logic [NSRC-1:0] active;
  logic [NSRC-1:0] w1c_clr;
  logic [NSRC-1:0] claim_clr;
  logic [3:0]      ins_id;
  logic            prio_valid;
  logic [3:0]      prio_id;
  state_t          state;
  state_t          state_nxt;

  logic wr_en;
  logic rd_en;
  logic claim_fire;
  logic eoi_wr;
  logic wdata_unused;

  // Upper write-data bits are meaningless when NSRC < 16 and EOI ignores the value.
  assign wdata_unused = ^bus.wdata;

`ifdef INTC_SYNC_EN
  logic [NSRC-1:0] sync1;
  logic [NSRC-1:0] sync2;

  // Two-flop synchronizer; preloaded with irq during reset so release sees no edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= irq;
      sync2 <= irq;
    end else begin
      sync1 <= irq;
      sync2 <= sync1;
    end
  end

  assign irq_s = sync2;
`else
  assign irq_s = irq;
`endif

  assign wr_en      = bus.cs & ~bus.rnw;
  assign rd_en      = bus.cs & bus.rnw;
  assign eoi_wr     = wr_en && (bus.address == OFS_EOI);
  assign claim_fire = rd_en && (bus.address == OFS_CLAIM) && (state == ST_ASSERT) && prio_valid;
  assign edge_det   = irq_s & ~irq_prev;
  assign active     = pending & mask;
  assign w1c_clr    = (wr_en && (bus.address == OFS_PENDING)) ? bus.wdata[NSRC-1:0] : '0;
  assign dbg_state  = state;

  opc5ls_intc_prio #(.NSRC(NSRC)) u_prio (
    .req   (active),
    .valid (prio_valid),
    .id    (prio_id)
  );

  // One-hot of the claimed source, restricted to edge sources.
  always_comb begin
    claim_clr = '0;
    for (int i = 0; i < NSRC; i++) begin
      claim_clr[i] = claim_fire && (prio_id == 4'(i)) && edge_mode[i];
    end
  end

  // Edge sources are sticky with clears losing to a new edge; level sources track irq.
  always_comb begin
    pending_nxt = (edge_mode & (edge_det | (pending & ~(w1c_clr | claim_clr))))
                | (~edge_mode & irq_s);
  end

  // Configuration, pending and edge-history registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending   <= '0;
      mask      <= '0;
      edge_mode <= '0;
      irq_prev  <= irq;
    end else begin
      pending  <= pending_nxt;
      irq_prev <= irq_s;
      if (wr_en && (bus.address == OFS_MASK)) mask      <= bus.wdata[NSRC-1:0];
      if (wr_en && (bus.address == OFS_EDGE)) edge_mode <= bus.wdata[NSRC-1:0];
    end
  end

  // Claim/EOI next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (|active) state_nxt = ST_ASSERT;
      end
      ST_ASSERT: begin
        if (claim_fire)    state_nxt = ST_INSERVICE;
        else if (~|active) state_nxt = ST_IDLE;
      end
      ST_INSERVICE: begin
        if (eoi_wr) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, in-service id and the registered interrupt line.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      int_b  <= 1'b1;
      ins_id <= 4'd0;
    end else begin
      state <= state_nxt;
      int_b <= (state_nxt != ST_ASSERT);
      if (claim_fire) ins_id <= prio_id;
    end
  end

  // Combinational register read mux.
  always_comb begin
    bus.rdata = 16'h0000;
    if (bus.cs) begin
      case (bus.address)
        OFS_PENDING: bus.rdata = 16'(pending);
        OFS_MASK:    bus.rdata = 16'(mask);
        OFS_EDGE:    bus.rdata = 16'(edge_mode);
        OFS_CLAIM:   bus.rdata = ((state == ST_ASSERT) && prio_valid) ? {12'h000, prio_id} : CLAIM_NONE;
        OFS_EOI:     bus.rdata = {12'h000, ins_id};
        OFS_STATUS:  bus.rdata = {14'b0, state};
        default:     bus.rdata = 16'h0000;
      endcase
    end
  end

endmodule

// File: doc/opc5ls_intc.md
OPC5LS_INTC -- requirements
Module: opc5ls_intc

Interface
REQ-001 SHALL have parameter NSRC, default 8, number of interrupt sources (legal 1..16).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, reset that is synchronous and active-high.
REQ-004 SHALL have port irq, input, NSRC, raw interrupt requests, bit 0 is the highest priority.
REQ-005 SHALL have port cs, input, 1, register-block select from the system address decoder.
REQ-006 SHALL have port address, input, 3, register offset, taken as CPU address[2:0].
REQ-007 SHALL have port rnw, input, 1, CPU read-not-write.
REQ-008 SHALL have port wdata, input, 16, CPU write data (CPU dout).
REQ-009 SHALL have port rdata, output, 16, read data, combinational from address and cs.
REQ-010 SHALL have port int_b, output, 1, registered active-low interrupt to the CPU int_b.

Function
REQ-011 SHALL implement this register map: 0 PENDING (R, W1C); 1 MASK (RW); 2 EDGE (RW, 1 = edge, 0 = level); 3 CLAIM (R, side effect); 4 EOI (W any value, R returns in-service id); 5 STATUS (R, {14'b0, state}).
REQ-012 SHALL return zero-extended NSRC-bit values and read 0 at unused offsets 6-7; writes there are ignored.
REQ-013 SHALL act on register side effects only on a clk edge with cs=1; a read side effect requires rnw=1, a write requires rnw=0.
REQ-014 SHALL, for an edge source, set the pending bit on the cycle after irq goes from 0 to 1; the bit stays set until cleared by W1C or CLAIM.
REQ-015 SHALL, for a level source, make the pending bit follow irq registered by one cycle; W1C and CLAIM have no effect on it.
REQ-016 SHALL let a new edge win over a W1C or CLAIM clear of the same bit in the same cycle, so the bit stays 1.
REQ-017 SHALL use a 2-bit FSM with states IDLE=0, ASSERT=1, INSERVICE=2.
REQ-018 SHALL, in IDLE, go to ASSERT and drive int_b low on the next edge when (pending & MASK) != 0.
REQ-019 SHALL, in ASSERT, on a CLAIM read: return the lowest set index of pending & MASK, latch it as the in-service id, clear that bit if it is an edge source, go to INSERVICE, and set int_b=1.
REQ-020 SHALL, in ASSERT, return to IDLE with int_b=1 on the next edge if pending & MASK becomes 0 through masking or W1C.
REQ-021 SHALL return 16'hFFFF for a CLAIM read when pending & MASK = 0 or the state is not ASSERT, with no state change.
REQ-022 SHALL, in INSERVICE, keep int_b=1 and go to IDLE on an EOI write; an EOI write in any other state is ignored.
REQ-023 SHALL apply a MASK or EDGE write to the gating from the following cycle.

Reset
REQ-024 SHALL, while reset=1, clear PENDING, MASK, EDGE and the in-service id, set state IDLE and int_b=1, and load the edge-detect history with the current irq so that no spurious edge is seen when reset is released.
REQ-025 SHALL, if reset is asserted mid-operation in any state, abandon the claim and discard pending edges.

Configuration
REQ-026 SHALL, with INTC_SYNC_EN defined, pass irq through a 2-flop synchronizer before edge and level detection, adding 2 cycles of latency to REQ-014, REQ-015 and REQ-018.
REQ-027 SHALL, without INTC_SYNC_EN, sample irq directly with no synchronizer.

Structure
REQ-028 SHALL take its register offsets (OFS_PENDING..OFS_STATUS), FSM state encodings and the CLAIM_NONE=16'hFFFF constant from the shared package opc5ls_intc_pkg.
REQ-029 SHALL place the lowest-index-first priority encoder in sub-module opc5ls_intc_prio, with outputs valid and a 4-bit id.

Verification
REQ-030 SHALL cover: MASK=0x0005, EDGE=0x0005, pulse irq[2] -> PENDING=0x0004, int_b low 2 cycles after the pulse; CLAIM reads 2; int_b high; STATUS=2.
REQ-031 SHALL cover: irq[0] and irq[2] edges in the same cycle -> CLAIM returns 0; after EOI, int_b reasserts; next CLAIM returns 2.
REQ-032 SHALL cover: level source 1 (EDGE bit 1 = 0, MASK=0x0002) held high -> CLAIM returns 1, EOI, int_b reasserts; after irq[1] drops and EOI, state=0 and int_b=1.
REQ-033 SHALL cover: in ASSERT, write MASK=0 -> next cycle state=0 and int_b=1; a CLAIM read returns 0xFFFF.
REQ-034 SHALL cover: a W1C of bit 3 in the same cycle as a new irq[3] edge -> PENDING bit 3 remains 1.
REQ-035 SHALL cover: reset pulsed in INSERVICE with irq[4] held high -> all registers 0, int_b=1, no pending bit after reset is released (edge mode); repeat with INTC_SYNC_EN defined and check the +2 cycle latency.
